// File: rtl/bus_capture_pkg.sv
// Shared constants and types for the output-bus capture FIFO.
package bus_capture_pkg;

  // Default widths: a 5-bit bus plus one companion bit, four entries deep.
  localparam int DEF_DATA_W = 5;
  localparam int DEF_DEPTH  = 4;

  // Pointers carry one extra bit beyond the index so full and empty differ.
  localparam int PTR_W = $clog2(DEF_DEPTH) + 1;

  // One captured word: {single, bus}.
  typedef logic [DEF_DATA_W:0] word_t;

endpackage

// File: rtl/capture_fifo_ptr.sv
// FIFO pointer: increments on request and wraps naturally mod 2**W.
module capture_fifo_ptr
  import bus_capture_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Pointer register; the MSB acts as the lap bit for full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/out_bus_capture_fifo.sv
// Captures {in_single, in_bus} into a small FIFO and hands words to a
// back-pressuring consumer.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. in_ready and out_valid depend only on registered
// pointers, never on in_valid/out_ready, so there is no combinational path
// between the upstream and downstream sides.
module out_bus_capture_fifo
  import bus_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_bus,
  input  logic                       in_single,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W:0]            out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = CNT_W - 1;

  logic [DATA_W:0] mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  capture_fifo_ptr #(.W(CNT_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  capture_fifo_ptr #(.W(CNT_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Status and transfer qualifiers, all from the registered pointers.
  always_comb begin
    wr_idx    = wr_ptr[IDX_W-1:0];
    rd_idx    = rd_ptr[IDX_W-1:0];
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_idx == rd_idx) && (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]);
    count     = wr_ptr - rd_ptr;
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid && !full;
    pop       = out_ready && !empty;
    out_data  = empty ? '0 : mem[rd_idx];
  end

  // Storage is deliberately not reset; the empty gate hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= {in_single, in_bus};
    end
  end

  // Sticky overflow: an offer while full sets it, and setting beats clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (in_valid && full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_out_bus_capture_fifo.sv
// Self-checking bench for out_bus_capture_fifo.
module tb_out_bus_capture_fifo;
  import bus_capture_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int CW = PTR_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_bus = '0;
  logic          in_single = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_ovf = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  word_t exp_q[$];

  typedef struct {
    string       name;
    logic        iv;
    logic [4:0]  bus;
    logic        single;
    logic        ordy;
    logic        clr;
    logic [2:0]  e_count;
    logic        e_ovalid;
    logic        e_iready;
    logic [5:0]  e_data;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  out_bus_capture_fifo #(.DATA_W(DW), .DEPTH(DEF_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus),
    .in_single (in_single),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic iv, input logic [4:0] bus,
                         input logic single, input logic ordy, input logic clr,
                         input logic [2:0] e_count, input logic e_ovalid,
                         input logic e_iready, input logic [5:0] e_data, input logic e_ovf);
    vec_t v;
    v.name = name; v.iv = iv; v.bus = bus; v.single = single; v.ordy = ordy; v.clr = clr;
    v.e_count = e_count; v.e_ovalid = e_ovalid; v.e_iready = e_iready;
    v.e_data = e_data; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  // Driver: set inputs on the falling edge.
  task automatic drive(input logic iv, input word_t w, input logic ordy, input logic clr);
    @(negedge clk);
    in_valid  = iv;
    in_bus    = w[DW-1:0];
    in_single = w[DW];
    out_ready = ordy;
    clr_ovf   = clr;
  endtask

  // Let one rising edge pass, then sample away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input word_t w);
    drive(1'b1, w, 1'b0, 1'b0);
    step();
    exp_q.push_back(w);
  endtask

  // Pop everything in the scoreboard, checking head order and final empty.
  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check({tag, "_head"}, 32'(out_data), 32'(exp_q[0]));
      step();
      void'(exp_q.pop_front());
      check({tag, "_cnt"}, 32'(count), 32'(exp_q.size()));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check({tag, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    word_t w;

    // Fill, overflow, drain, then empty-with-ready and first push.
    add_vec("fill0", 1, 5'h11, 1, 0, 0, 3'd1, 1, 1, 6'h31, 0);
    add_vec("fill1", 1, 5'h02, 0, 0, 0, 3'd2, 1, 1, 6'h31, 0);
    add_vec("fill2", 1, 5'h1F, 1, 0, 0, 3'd3, 1, 1, 6'h31, 0);
    add_vec("fill3", 1, 5'h00, 0, 0, 0, 3'd4, 1, 0, 6'h31, 0);
    add_vec("ovf_set", 1, 5'h0A, 0, 0, 0, 3'd4, 1, 0, 6'h31, 1);
    add_vec("ovf_set_clr", 1, 5'h15, 1, 0, 1, 3'd4, 1, 0, 6'h31, 1);
    add_vec("ovf_clr", 0, 5'h00, 0, 0, 1, 3'd4, 1, 0, 6'h31, 0);
    add_vec("drain0", 0, 5'h00, 0, 1, 0, 3'd3, 1, 1, 6'h02, 0);
    add_vec("drain1", 0, 5'h00, 0, 1, 0, 3'd2, 1, 1, 6'h3F, 0);
    add_vec("drain2", 0, 5'h00, 0, 1, 0, 3'd1, 1, 1, 6'h00, 0);
    add_vec("drain3", 0, 5'h00, 0, 1, 0, 3'd0, 0, 1, 6'h00, 0);
    for (int i = 0; i < 5; i++)
      add_vec("empty_rdy", 0, 5'h00, 0, 1, 0, 3'd0, 0, 1, 6'h00, 0);
    add_vec("first_push", 1, 5'h05, 1, 0, 0, 3'd1, 1, 1, 6'h25, 0);
    add_vec("last_pop", 0, 5'h00, 0, 1, 0, 3'd0, 0, 1, 6'h00, 0);

    // Reset values while rst_n is low.
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_iready", 32'(in_ready), 32'd1);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, {vecs[i].single, vecs[i].bus}, vecs[i].ordy, vecs[i].clr);
      step();
      check({vecs[i].name, "_count"}, 32'(count), 32'(vecs[i].e_count));
      check({vecs[i].name, "_ovalid"}, 32'(out_valid), 32'(vecs[i].e_ovalid));
      check({vecs[i].name, "_iready"}, 32'(in_ready), 32'(vecs[i].e_iready));
      check({vecs[i].name, "_data"}, 32'(out_data), 32'(vecs[i].e_data));
      check({vecs[i].name, "_ovf"}, 32'(overflow), 32'(vecs[i].e_ovf));
    end

    // Concurrent push+pop at count 2; pointers wrap several times.
    push_word(6'h0C);
    push_word(6'h33);
    for (int i = 0; i < 10; i++) begin
      w = word_t'((i * 7 + 3) % 64);
      drive(1'b1, w, 1'b1, 1'b0);
      check("conc_head", 32'(out_data), 32'(exp_q[0]));
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(w);
      check("conc_count", 32'(count), 32'd2);
    end
    drain("conc_drain");

    // Full with simultaneous offer and pop: pop wins, push lands next cycle.
    push_word(6'h01);
    push_word(6'h22);
    push_word(6'h13);
    push_word(6'h34);
    check("full_iready", 32'(in_ready), 32'd0);
    drive(1'b1, 6'h2E, 1'b1, 1'b0);
    step();
    void'(exp_q.pop_front());
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_iready", 32'(in_ready), 32'd1);
    check("fullpop_head", 32'(out_data), 32'(exp_q[0]));
    check("fullpop_ovf", 32'(overflow), 32'd1);
    drive(1'b1, 6'h2E, 1'b0, 1'b0);
    step();
    exp_q.push_back(6'h2E);
    check("late_push_count", 32'(count), 32'd4);
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    check("fullpop_ovf_clr", 32'(overflow), 32'd0);
    drain("fullpop_drain");

    // Asynchronous reset mid-stream with three entries queued.
    push_word(6'h0F);
    push_word(6'h10);
    push_word(6'h2B);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_ovalid", 32'(out_valid), 32'd0);
    check("arst_iready", 32'(in_ready), 32'd1);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ovalid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
